// File: rtl/cpu_package.sv
// Shared CPU types: ALU function codes and ID/EX operand source selects.
package cpu_package;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_AND    = 4'd2,
      ALU_OR     = 4'd3,
      ALU_XOR    = 4'd4,
      ALU_SLT    = 4'd5,
      ALU_SLTU   = 4'd6,
      ALU_SLL    = 4'd7,
      ALU_SRL    = 4'd8,
      ALU_SRA    = 4'd9
   } alu_function_t;

   typedef enum logic {
      OPA_RS1 = 1'b0,
      OPA_PC  = 1'b1
   } operand_a_sel_t;

   typedef enum logic {
      OPB_RS2 = 1'b0,
      OPB_IMM = 1'b1
   } operand_b_sel_t;

endpackage

// File: rtl/id_ex_stage_operand_forward.sv
// Per-source operand resolution: picks the freshest value for one register and flags a RAW hazard.
// ID_EX_FORWARD_EN selects MEM/WB forwarding; without it any in-flight writer match interlocks.
module operand_forward #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs_addr_i,
   input  logic                  used_i,
   input  logic [XLEN-1:0]       stored_data_i,
   input  logic [REG_ADDR_W-1:0] mem_rd_addr_i,
   input  logic                  mem_reg_write_i,
   input  logic                  mem_is_load_i,
   input  logic [XLEN-1:0]       mem_result_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
   input  logic                  wb_reg_write_i,
   input  logic [XLEN-1:0]       wb_data_i,
   output logic [XLEN-1:0]       fwd_data_o,
   output logic                  hazard_o
);

   logic rs_nonzero;
   logic mem_hit;
   logic wb_hit;

   assign rs_nonzero = (rs_addr_i != '0);
   assign mem_hit    = mem_reg_write_i & rs_nonzero & (mem_rd_addr_i == rs_addr_i);
   assign wb_hit     = wb_reg_write_i  & rs_nonzero & (wb_rd_addr_i  == rs_addr_i);

`ifdef ID_EX_FORWARD_EN
   always_comb begin
      fwd_data_o = stored_data_i;
      if (!rs_nonzero)                  fwd_data_o = '0;
      else if (mem_hit && !mem_is_load_i) fwd_data_o = mem_result_i;
      else if (wb_hit)                  fwd_data_o = wb_data_i;
   end

   // A load result is not available until it reaches WB.
   assign hazard_o = used_i & mem_hit & mem_is_load_i;
`else
   logic unused_fwd;

   assign unused_fwd = ^{mem_result_i, wb_data_i, mem_is_load_i};
   assign fwd_data_o = rs_nonzero ? stored_data_i : '0;
   assign hazard_o   = used_i & (mem_hit | wb_hit);
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with WB snooping and RAW hazard resolution.
// Define ID_EX_FORWARD_EN to forward from MEM/WB; otherwise matching writers interlock.
module id_ex_stage
   import cpu_package::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       in_pc,
   input  logic [REG_ADDR_W-1:0] in_rs1_addr,
   input  logic [REG_ADDR_W-1:0] in_rs2_addr,
   input  logic [XLEN-1:0]       in_rs1_data,
   input  logic [XLEN-1:0]       in_rs2_data,
   input  logic [XLEN-1:0]       in_imm,
   input  operand_a_sel_t        in_a_sel,
   input  operand_b_sel_t        in_b_sel,
   input  alu_function_t         in_alu_control,
   input  logic [REG_ADDR_W-1:0] in_rd_addr,
   input  logic                  in_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_rd_addr,
   input  logic                  mem_reg_write,
   input  logic                  mem_is_load,
   input  logic [XLEN-1:0]       mem_result,
   input  logic [REG_ADDR_W-1:0] wb_rd_addr,
   input  logic                  wb_reg_write,
   input  logic [XLEN-1:0]       wb_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output alu_function_t         out_alu_control,
   output logic [XLEN-1:0]       out_a,
   output logic [XLEN-1:0]       out_b,
   output logic [XLEN-1:0]       out_pc,
   output logic [REG_ADDR_W-1:0] out_rd_addr,
   output logic                  out_reg_write
);

   logic                  valid_q,    valid_d;
   logic [XLEN-1:0]       pc_q,       pc_d;
   logic [REG_ADDR_W-1:0] rs1_addr_q, rs1_addr_d;
   logic [REG_ADDR_W-1:0] rs2_addr_q, rs2_addr_d;
   logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
   logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
   logic [XLEN-1:0]       imm_q,      imm_d;
   operand_a_sel_t        a_sel_q,    a_sel_d;
   operand_b_sel_t        b_sel_q,    b_sel_d;
   alu_function_t         alu_q,      alu_d;
   logic [REG_ADDR_W-1:0] rd_q,       rd_d;
   logic                  rw_q,       rw_d;

   logic            rs1_used, rs2_used;
   logic            rs1_haz,  rs2_haz;
   logic [XLEN-1:0] rs1_fwd,  rs2_fwd;
   logic            hazard, capture, xfer_out;

   assign rs1_used = (a_sel_q == OPA_RS1) & (rs1_addr_q != '0);
   assign rs2_used = (b_sel_q == OPB_RS2) & (rs2_addr_q != '0);

   operand_forward #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
      .rs_addr_i       (rs1_addr_q),
      .used_i          (rs1_used),
      .stored_data_i   (rs1_data_q),
      .mem_rd_addr_i   (mem_rd_addr),
      .mem_reg_write_i (mem_reg_write),
      .mem_is_load_i   (mem_is_load),
      .mem_result_i    (mem_result),
      .wb_rd_addr_i    (wb_rd_addr),
      .wb_reg_write_i  (wb_reg_write),
      .wb_data_i       (wb_data),
      .fwd_data_o      (rs1_fwd),
      .hazard_o        (rs1_haz)
   );

   operand_forward #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
      .rs_addr_i       (rs2_addr_q),
      .used_i          (rs2_used),
      .stored_data_i   (rs2_data_q),
      .mem_rd_addr_i   (mem_rd_addr),
      .mem_reg_write_i (mem_reg_write),
      .mem_is_load_i   (mem_is_load),
      .mem_result_i    (mem_result),
      .wb_rd_addr_i    (wb_rd_addr),
      .wb_reg_write_i  (wb_reg_write),
      .wb_data_i       (wb_data),
      .fwd_data_o      (rs2_fwd),
      .hazard_o        (rs2_haz)
   );

   assign hazard   = valid_q & (rs1_haz | rs2_haz);
   assign out_valid = valid_q & ~hazard;
   assign in_ready  = ~valid_q | (out_ready & ~hazard);
   assign xfer_out  = out_valid & out_ready;
   assign capture   = in_valid & in_ready & ~flush;

   always_comb begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      a_sel_d    = a_sel_q;
      b_sel_d    = b_sel_q;
      alu_d      = alu_q;
      rd_d       = rd_q;
      rw_d       = rw_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (capture) begin
         valid_d    = 1'b1;
         pc_d       = in_pc;
         rs1_addr_d = in_rs1_addr;
         rs2_addr_d = in_rs2_addr;
         rs1_data_d = in_rs1_data;
         rs2_data_d = in_rs2_data;
         imm_d      = in_imm;
         a_sel_d    = in_a_sel;
         b_sel_d    = in_b_sel;
         alu_d      = in_alu_control;
         rd_d       = in_rd_addr;
         rw_d       = in_reg_write;
      end else begin
         if (xfer_out) valid_d = 1'b0;
         // Keep held operands current with the register file while waiting.
         if (valid_q && wb_reg_write && (wb_rd_addr != '0)) begin
            if (wb_rd_addr == rs1_addr_q) rs1_data_d = wb_data;
            if (wb_rd_addr == rs2_addr_q) rs2_data_d = wb_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         a_sel_q    <= OPA_RS1;
         b_sel_q    <= OPB_RS2;
         alu_q      <= ALU_ADD;
         rd_q       <= '0;
         rw_q       <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         a_sel_q    <= a_sel_d;
         b_sel_q    <= b_sel_d;
         alu_q      <= alu_d;
         rd_q       <= rd_d;
         rw_q       <= rw_d;
      end
   end

   assign out_a           = (a_sel_q == OPA_PC)  ? pc_q  : rs1_fwd;
   assign out_b           = (b_sel_q == OPB_IMM) ? imm_q : rs2_fwd;
   assign out_pc          = pc_q;
   assign out_alu_control = alu_q;
   assign out_rd_addr     = rd_q;
   assign out_reg_write   = rw_q;

endmodule
